// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer constants and Gray/binary helpers for the async FIFO controllers
package async_fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into ptr_t and truncate the result
    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_gray2bin.sv
// rtl/async_fifo_gray2bin.sv - combinational Gray-to-binary converter for a synchronized pointer
module async_fifo_gray2bin
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] GRAY,
    output logic [WIDTH-1:0] BIN
);

    // Zero-extension keeps the upper XOR chain neutral, so truncating back is exact
    assign BIN = WIDTH'(gray2bin(ptr_t'(GRAY)));

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain pointer, full/almost-full, level and overflow control
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_INC,
    input  logic [ADDR_WIDTH:0]   RQ_PTR,
    input  logic                  OVF_CLR,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [ADDR_WIDTH:0]   WQ_PTR,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   WR_LEVEL,
    output logic                  OVERFLOW
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    async_fifo_gray2bin #(
        .WIDTH(PW)
    ) u_rq_gray2bin (
        .GRAY(RQ_PTR),
        .BIN (rbin)
    );

    // Only registered FULL gates the strobe, so RQ_PTR never reaches an output combinationally
    assign WR_EN      = WR_INC & ~FULL & ~RST;
    assign WR_ADDR    = wbin[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin + PW'(WR_EN);
    assign wgray_next = PW'(bin2gray(ptr_t'(wbin_next)));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal
    assign full_cmp   = {~RQ_PTR[ADDR_WIDTH:ADDR_WIDTH-1], RQ_PTR[ADDR_WIDTH-2:0]};
    assign full_next  = (wgray_next == full_cmp);

    // Level uses the post-write pointer and the current read pointer, so a write and read in the same cycle net out
    assign level_next = wbin_next - rbin;
    assign afull_next = (level_next >= PW'(AFULL_THRESH));

    // Pointer, Gray output and status flags all advance together from the same next-state values
    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin        <= '0;
            WQ_PTR      <= '0;
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            WR_LEVEL    <= '0;
        end else begin
            wbin        <= wbin_next;
            WQ_PTR      <= wgray_next;
            FULL        <= full_next;
            ALMOST_FULL <= afull_next;
            WR_LEVEL    <= level_next;
        end
    end

    // Sticky overflow: a rejected write wins over a clear in the same cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (WR_INC && FULL) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - scoreboard bench for async_fifo_wr_ctrl against an occupancy-count model
module tb_async_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int THR   = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WR_INC;
    logic [PW-1:0] RQ_PTR;
    logic          OVF_CLR;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [PW-1:0] WQ_PTR;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [PW-1:0] WR_LEVEL;
    logic          OVERFLOW;

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH  (AW),
        .AFULL_THRESH(THR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_INC     (WR_INC),
        .RQ_PTR     (RQ_PTR),
        .OVF_CLR    (OVF_CLR),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WQ_PTR     (WQ_PTR),
        .FULL       (FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .WR_LEVEL   (WR_LEVEL),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int wr_en;
        int addr;
        int wq;
        int full;
        int afull;
        int level;
        int ovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: total words written and read since reset; occupancy is their difference
    int wcnt  = 0;
    int rcnt  = 0;
    int rseen = 0;
    int ovf   = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & ((1 << PW) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, queue what the DUT must show this cycle, then advance the model
    task automatic cyc(input int inc, input int clr, input int rst);
        exp_t e;
        int   lvl;
        int   full_now;
        if (rst != 0) rcnt = 0;
        WR_INC  = (inc != 0);
        OVF_CLR = (clr != 0);
        RST     = (rst != 0);
        RQ_PTR  = PW'(gray(rcnt % (2 * DEPTH)));
        lvl      = wcnt - rseen;
        full_now = (lvl == DEPTH) ? 1 : 0;
        e.wr_en = (inc != 0 && full_now == 0 && rst == 0) ? 1 : 0;
        e.addr  = wcnt % DEPTH;
        e.wq    = gray(wcnt % (2 * DEPTH));
        e.full  = full_now;
        e.afull = (lvl >= THR) ? 1 : 0;
        e.level = lvl;
        e.ovf   = ovf;
        sb.push_back(e);
        @(posedge CLK);
        if (rst != 0) begin
            wcnt  = 0;
            rseen = 0;
            ovf   = 0;
        end else begin
            if (inc != 0 && full_now == 0) wcnt++;
            if (inc != 0 && full_now != 0) ovf = 1;
            else if (clr != 0) ovf = 0;
            rseen = rcnt;
        end
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output set, compared at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_en",       32'(WR_EN),       32'(e.wr_en));
                chk("wr_addr",     32'(WR_ADDR),     32'(e.addr));
                chk("wq_ptr",      32'(WQ_PTR),      32'(e.wq));
                chk("full",        32'(FULL),        32'(e.full));
                chk("almost_full", 32'(ALMOST_FULL), 32'(e.afull));
                chk("wr_level",    32'(WR_LEVEL),    32'(e.level));
                chk("overflow",    32'(OVERFLOW),    32'(e.ovf));
            end
        end
    end

    initial begin
        int room;
        RST = 1'b1; WR_INC = 1'b0; OVF_CLR = 1'b0; RQ_PTR = '0;
        @(posedge CLK);
        #1;

        // Reset state
        cyc(0, 0, 1);
        chk("rst_wq_ptr",   32'(WQ_PTR),   32'h0);
        chk("rst_full",     32'(FULL),     32'h0);
        chk("rst_level",    32'(WR_LEVEL), 32'h0);
        chk("rst_overflow", 32'(OVERFLOW), 32'h0);

        // Fill all eight slots with the reader idle
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 0, 0);
            if (i == THR - 1) chk("afull_at_6", 32'(ALMOST_FULL), 32'h1);
        end
        chk("fill_wq_ptr", 32'(WQ_PTR),   32'hC);
        chk("fill_full",   32'(FULL),     32'h1);
        chk("fill_level",  32'(WR_LEVEL), 32'h8);

        // Writes while full are rejected and flag overflow; clear behaviour
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("ovf_set",      32'(OVERFLOW), 32'h1);
        chk("ovf_wq_held",  32'(WQ_PTR),   32'hC);
        cyc(0, 1, 0);
        chk("ovf_cleared",  32'(OVERFLOW), 32'h0);
        cyc(1, 1, 0);
        chk("ovf_set_wins", 32'(OVERFLOW), 32'h1);
        cyc(0, 1, 0);

        // Reader frees one slot; the next write refills it
        rcnt = 1;
        cyc(1, 0, 0);
        chk("step_full",   32'(FULL),     32'h0);
        chk("step_level",  32'(WR_LEVEL), 32'h7);
        cyc(1, 0, 0);
        chk("refill_full",  32'(FULL),     32'h1);
        chk("refill_level", 32'(WR_LEVEL), 32'h8);

        // Reset mid-write after five writes, then first write lands at address 0
        cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("midrst_addr",  32'(WR_ADDR),  32'h0);
        chk("midrst_wq",    32'(WQ_PTR),   32'h0);
        chk("midrst_level", 32'(WR_LEVEL), 32'h0);
        cyc(1, 0, 0);
        chk("post_rst_addr", 32'(WR_ADDR), 32'h1);

        // Streaming with reader trailing two words behind: wraps the pointer, never fills
        cyc(0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            rcnt = (wcnt >= 2) ? wcnt - 2 : 0;
            cyc(1, 0, 0);
            chk("stream_not_full", 32'(FULL), 32'h0);
        end

        // Randomized traffic, occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                cyc(int'($urandom_range(0, 1)), 0, 1);
            end else begin
                room = wcnt - rcnt;
                rcnt = rcnt + int'($urandom_range(0, (room > 2) ? 2 : room));
                cyc(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0, 0);
            end
        end

        WR_INC = 1'b0;
        OVF_CLR = 1'b0;
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
